ltc2308_ctrl: RTL and testbench



---
 rtl/ltc2308_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_ltc2308_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ltc2308_ctrl.sv
// LTC2308 SPI ADC sequencer: round-robin scan of enabled channels. Each result is tagged
// with the channel whose config word was sent one frame earlier.
module ltc2308_ctrl #(
  parameter int SCK_HALF   = 1,
  parameter int CONVST_CYC = 1,
  parameter int CONV_CYC   = 80,
  parameter int FRAME_CYC  = 110
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [7:0]  ch_mask,
  input  logic        uni,
  output logic        adc_convst,
  output logic        adc_sck,
  output logic        adc_sdi,
  input  logic        adc_sdo,
  output logic        res_valid,
  output logic [2:0]  res_ch,
  output logic [11:0] res_data,
  output logic        busy
);

  localparam int CW = $clog2(FRAME_CYC);
  localparam int HW = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;
  localparam logic [CW-1:0] CONVST_LAST = CW'(CONVST_CYC - 1);
  localparam logic [CW-1:0] CONV_LAST   = CW'(CONV_CYC - 1);
  localparam logic [CW-1:0] FRAME_LAST  = CW'(FRAME_CYC - 1);
  localparam logic [HW-1:0] HALF_LAST   = HW'(SCK_HALF - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONV_HI,
    S_CONV_WAIT,
    S_SHIFT,
    S_GUARD
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [HW-1:0] r_half, w_half_nxt;
  logic [3:0]  r_nrise, w_nrise_nxt;
  logic        r_sck, w_sck_nxt;
  logic        r_convst, w_convst_nxt;
  logic [5:0]  r_sdi_word, w_sdi_word_nxt;
  logic [11:0] r_shreg, w_shreg_nxt;
  logic [2:0]  r_cur_ch, w_cur_ch_nxt;
  logic [2:0]  r_prev_ch, w_prev_ch_nxt;
  logic        r_prime, w_prime_nxt;
  logic        r_cap12, w_cap12_nxt;
  logic        r_res_valid, w_res_valid_nxt;
  logic [2:0]  r_res_ch, w_res_ch_nxt;
  logic [11:0] r_res_data, w_res_data_nxt;

  logic        w_run;
  logic        w_start;
  logic        w_found_above;
  logic [2:0]  w_lowest;
  logic [2:0]  w_above;
  logic [2:0]  w_next_ch;

  assign w_run = enable && (ch_mask != 8'h00);

  // Scanning downwards leaves the lowest matching index in each result.
  always_comb begin
    w_lowest      = 3'd0;
    w_above       = 3'd0;
    w_found_above = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (ch_mask[i]) begin
        w_lowest = 3'(i);
        if (3'(i) > r_cur_ch) begin
          w_above       = 3'(i);
          w_found_above = 1'b1;
        end
      end
    end
    w_next_ch = w_found_above ? w_above : w_lowest;
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt + 1'b1;
    w_half_nxt      = r_half;
    w_nrise_nxt     = r_nrise;
    w_sck_nxt       = 1'b0;
    w_convst_nxt    = 1'b0;
    w_sdi_word_nxt  = r_sdi_word;
    w_shreg_nxt     = r_shreg;
    w_cur_ch_nxt    = r_cur_ch;
    w_prev_ch_nxt   = r_prev_ch;
    w_prime_nxt     = r_prime;
    w_cap12_nxt     = 1'b0;
    w_res_valid_nxt = 1'b0;
    w_res_ch_nxt    = r_res_ch;
    w_res_data_nxt  = r_res_data;
    w_start         = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (w_run) begin
          w_start     = 1'b1;
          w_prime_nxt = 1'b1;
        end
      end
      S_CONV_HI: begin
        if (r_cnt == CONVST_LAST) w_state_nxt = S_CONV_WAIT;
      end
      S_CONV_WAIT: begin
        if (r_cnt == CONV_LAST) begin
          w_state_nxt = S_SHIFT;
          w_half_nxt  = '0;
          w_nrise_nxt = 4'd0;
        end
      end
      S_SHIFT: begin
        w_sck_nxt = r_sck;
        if (r_half == HALF_LAST) begin
          w_half_nxt = '0;
          // Rising SCK samples SDO settled since the previous fall; falling SCK advances SDI.
          if (!r_sck) begin
            w_sck_nxt   = 1'b1;
            w_shreg_nxt = {r_shreg[10:0], adc_sdo};
            w_nrise_nxt = r_nrise + 4'd1;
            w_cap12_nxt = (r_nrise == 4'd11);
          end else begin
            w_sck_nxt = 1'b0;
            if (r_nrise == 4'd12) w_state_nxt = S_GUARD;
            else                  w_sdi_word_nxt = {r_sdi_word[4:0], 1'b0};
          end
        end else begin
          w_half_nxt = r_half + 1'b1;
        end
      end
      S_GUARD: begin
        if (r_cnt == FRAME_LAST) begin
          if (w_run) begin
            w_start = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase

    if (w_start) begin
      w_state_nxt    = S_CONV_HI;
      w_cnt_nxt      = '0;
      w_cur_ch_nxt   = w_next_ch;
      w_prev_ch_nxt  = r_cur_ch;
      w_sdi_word_nxt = {1'b1, w_next_ch[0], w_next_ch[2], w_next_ch[1], uni, 1'b0};
    end

    // The first frame after leaving IDLE converts with an unknown config, so it is dropped.
    if (r_cap12) begin
      if (r_prime) begin
        w_prime_nxt = 1'b0;
      end else begin
        w_res_valid_nxt = 1'b1;
        w_res_ch_nxt    = r_prev_ch;
        w_res_data_nxt  = r_shreg;
      end
    end

    w_convst_nxt = (w_state_nxt == S_CONV_HI);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_half      <= '0;
      r_nrise     <= 4'd0;
      r_sck       <= 1'b0;
      r_convst    <= 1'b0;
      r_sdi_word  <= 6'd0;
      r_shreg     <= 12'd0;
      r_cur_ch    <= 3'd0;
      r_prev_ch   <= 3'd0;
      r_prime     <= 1'b1;
      r_cap12     <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_ch    <= 3'd0;
      r_res_data  <= 12'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_half      <= w_half_nxt;
      r_nrise     <= w_nrise_nxt;
      r_sck       <= w_sck_nxt;
      r_convst    <= w_convst_nxt;
      r_sdi_word  <= w_sdi_word_nxt;
      r_shreg     <= w_shreg_nxt;
      r_cur_ch    <= w_cur_ch_nxt;
      r_prev_ch   <= w_prev_ch_nxt;
      r_prime     <= w_prime_nxt;
      r_cap12     <= w_cap12_nxt;
      r_res_valid <= w_res_valid_nxt;
      r_res_ch    <= w_res_ch_nxt;
      r_res_data  <= w_res_data_nxt;
    end
  end

  assign adc_convst = r_convst;
  assign adc_sck    = r_sck;
  assign adc_sdi    = r_sdi_word[5];
  assign res_valid  = r_res_valid;
  assign res_ch     = r_res_ch;
  assign res_data   = r_res_data;
  assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_ltc2308_ctrl.sv
// Bench for ltc2308_ctrl: behavioural LTC2308 model with timing checks, plus a result
// scoreboard keyed by frame number, channel tag and data.
`timescale 1ns/1ps
module tb_ltc2308_ctrl;

  localparam int CONVST_CYC = 1;
  localparam int CONV_CYC   = 80;
  localparam int FRAME_CYC  = 110;

  typedef struct {
    int         frame;
    logic [2:0] ch;
    logic [11:0] data;
  } expT;

  logic        clock = 1'b0;
  logic        rstN = 1'b0;
  logic        enable = 1'b0;
  logic [7:0]  chMask = 8'h00;
  logic        uniIn = 1'b0;
  logic        adcConvst, adcSck, adcSdi;
  logic        adcSdo = 1'b0;
  logic        resValid;
  logic [2:0]  resCh;
  logic [11:0] resData;
  logic        busy;

  int nTests = 0;
  int nFail = 0;
  expT expQ[$];
  expT popped;

  logic [11:0] chanVal [0:7] = '{12'hA5C, 12'h001, 12'h002, 12'h3C3,
                                 12'h4B4, 12'h005, 12'h6A6, 12'h007};
  int          cyc = 0;
  int          lastRise = 0;
  int          riseCount = 0;
  int          frameNo = 0;
  int          wordBits = 0;
  int          sdoIdx = 0;
  bit          contig = 1'b0;
  logic        convstQ = 1'b0;
  logic        sckQ = 1'b0;
  logic [5:0]  wordSh = 6'd0;
  logic [2:0]  convCh = 3'd3;
  logic [11:0] convVal = 12'd0;
  int          base;
  int          n;
  int          r0;

  ltc2308_ctrl dut (
    .clk       (clock),
    .rst_n     (rstN),
    .enable    (enable),
    .ch_mask   (chMask),
    .uni       (uniIn),
    .adc_convst(adcConvst),
    .adc_sck   (adcSck),
    .adc_sdi   (adcSdi),
    .adc_sdo   (adcSdo),
    .res_valid (resValid),
    .res_ch    (resCh),
    .res_data  (resData),
    .busy      (busy)
  );

  always #10 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nTests++;
    if (actual !== expected) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic waitCycle();
    @(negedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic en, input logic [7:0] mask, input logic u);
    enable = en;
    chMask = mask;
    uniIn  = u;
  endtask

  task automatic pushExp(input int frame, input logic [2:0] ch, input logic [11:0] data);
    expT e;
    e.frame = frame;
    e.ch    = ch;
    e.data  = data;
    expQ.push_back(e);
  endtask

  task automatic waitFrame(input string name, input int target);
    for (int i = 0; i < 400 && frameNo < target; i++) waitCycle();
    checkOutput(name, frameNo >= target, 1);
  endtask

  // Disabling inside the last result's GUARD lets the frame end cleanly with no extra frame.
  task automatic drainAndStop(input string name);
    for (int i = 0; i < 1500 && expQ.size() != 0; i++) waitCycle();
    checkOutput({name, "_drain"}, expQ.size(), 0);
    enable = 1'b0;
    for (int i = 0; i < 200 && busy; i++) waitCycle();
    checkOutput({name, "_idle"}, busy, 0);
  endtask

  // ADC model: config word from frame N selects the channel converted at frame N+1.
  always @(negedge clock) begin
    cyc++;
    if (!busy) contig = 1'b0;
    if (adcConvst && !convstQ) begin
      riseCount++;
      if (contig) checkOutput("frame_period", cyc - lastRise, FRAME_CYC);
      contig   = 1'b1;
      lastRise = cyc;
      frameNo++;
      if (wordBits >= 6) convCh = {wordSh[3], wordSh[2], wordSh[4]};
      convVal  = chanVal[convCh];
      sdoIdx   = 11;
      adcSdo   = convVal[11];
      wordBits = 0;
    end
    if (!adcConvst && convstQ) checkOutput("convst_width", cyc - lastRise, CONVST_CYC);
    if (adcSck && !sckQ) begin
      checkOutput("sck_after_convst", (cyc - lastRise) >= CONV_CYC, 1);
      if (wordBits < 6) begin
        wordSh = {wordSh[4:0], adcSdi};
        wordBits++;
        if (wordBits == 6)
          checkOutput("sdi_fixed_bits", {wordSh[5], wordSh[1], wordSh[0]}, {1'b1, uniIn, 1'b0});
      end
    end
    if (!adcSck && sckQ && sdoIdx > 0) begin
      sdoIdx--;
      adcSdo = convVal[sdoIdx];
    end
    convstQ = adcConvst;
    sckQ    = adcSck;
  end

  always @(negedge clock) begin
    if (resValid) begin
      checkOutput("result_expected", expQ.size() > 0, 1);
      if (expQ.size() > 0) begin
        popped = expQ.pop_front();
        checkOutput("res_frame", frameNo, popped.frame);
        checkOutput("res_ch", resCh, popped.ch);
        checkOutput("res_data", resData, popped.data);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    applyStimulus(1'b0, 8'h00, 1'b0);
    rstN = 1'b0;
    repeat (3) waitCycle();
    checkOutput("reset_outputs", {adcConvst, adcSck, adcSdi, resValid, busy, resCh, resData}, 0);
    rstN = 1'b1;

    $display("[TB] single channel CH0, first frame dropped");
    base = frameNo;
    pushExp(base + 2, 3'd0, 12'hA5C);
    pushExp(base + 3, 3'd0, 12'hA5C);
    pushExp(base + 4, 3'd0, 12'hA5C);
    applyStimulus(1'b1, 8'h01, 1'b0);
    drainAndStop("single_ch");

    $display("[TB] empty mask stays idle");
    r0 = riseCount;
    applyStimulus(1'b1, 8'h00, 1'b0);
    repeat (300) waitCycle();
    checkOutput("mask0_no_convst", riseCount - r0, 0);
    checkOutput("mask0_idle", busy, 0);
    enable = 1'b0;

    $display("[TB] disable mid-shift, then re-enable");
    base = frameNo;
    pushExp(base + 2, 3'd0, 12'hA5C);
    applyStimulus(1'b1, 8'h01, 1'b0);
    waitFrame("dis_frame2", base + 2);
    n = 0;
    repeat (85) begin waitCycle(); n++; end
    enable = 1'b0;
    while (busy && n < 300) begin waitCycle(); n++; end
    checkOutput("dis_busy_fall", n, FRAME_CYC);
    repeat (20) waitCycle();
    checkOutput("dis_drained", expQ.size(), 0);
    base = frameNo;
    pushExp(base + 2, 3'd0, 12'hA5C);
    applyStimulus(1'b1, 8'h01, 1'b0);
    drainAndStop("reenable");

    $display("[TB] round-robin over CH1/2/5/7, unipolar");
    base = frameNo;
    pushExp(base + 2, 3'd1, 12'h001);
    pushExp(base + 3, 3'd2, 12'h002);
    pushExp(base + 4, 3'd5, 12'h005);
    pushExp(base + 5, 3'd7, 12'h007);
    pushExp(base + 6, 3'd1, 12'h001);
    applyStimulus(1'b1, 8'b1010_0110, 1'b1);
    drainAndStop("scan");

    $display("[TB] reset pulse mid-shift");
    applyStimulus(1'b1, 8'h01, 1'b0);
    base = frameNo;
    waitFrame("rst_frame2", base + 2);
    repeat (86) waitCycle();
    rstN = 1'b0;
    waitCycle();
    checkOutput("rst_sck", adcSck, 0);
    checkOutput("rst_convst", adcConvst, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_valid", resValid, 0);
    base = frameNo;
    pushExp(base + 2, 3'd0, 12'hA5C);
    pushExp(base + 3, 3'd0, 12'hA5C);
    rstN = 1'b1;
    drainAndStop("after_reset");

    $display("[TB] mask change CH0 to CH7 mid-frame");
    base = frameNo;
    pushExp(base + 2, 3'd0, 12'hA5C);
    pushExp(base + 3, 3'd0, 12'hA5C);
    pushExp(base + 4, 3'd7, 12'h007);
    pushExp(base + 5, 3'd7, 12'h007);
    applyStimulus(1'b1, 8'h01, 1'b0);
    waitFrame("mask_frame2", base + 2);
    repeat (20) waitCycle();
    chMask = 8'h80;
    drainAndStop("mask_change");

    repeat (20) waitCycle();
    checkOutput("scoreboard_empty", expQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
